// File: rtl/ef_dac12_pkg.sv
// Shared definitions for the 12-bit DAC controller slice.
//   state_t             : controller FSM states
//   DEFAULT_NUM_BITS    : default DAC code width
//   DEFAULT_FIFO_DEPTH  : default sample-FIFO depth (power of two, >= 2)
//   SETTLE_BITS         : width of the settle count field in ConfigBits
package ef_dac12_pkg;

    localparam int DEFAULT_NUM_BITS   = 12;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int SETTLE_BITS        = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ef_dac12_fifo.sv
// Synchronous sample FIFO for the DAC controller.
// The head word is always visible on rd_data so that the controller can
// capture it on the same edge that pops it.
// Ports:
//   clk, srst        : clock, synchronous active-high reset
//   wr_en, wr_data   : write request; ignored when full at the start of the cycle
//   rd_en            : pop request; ignored when empty
//   rd_data          : current head word
//   full, empty      : occupancy flags (from the registered level)
//   level            : number of stored words
module ef_dac12_fifo
    import ef_dac12_pkg::*;
#(
    parameter int WIDTH = DEFAULT_NUM_BITS,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             push;
    logic             pop;

    // Full/empty come from the registered level, so a pop in the same
    // cycle never makes room for a write.
    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_reg[rd_ptr_reg];
    assign level   = level_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Storage has no reset so it can map onto RAM; reset still blocks writes.
    always_ff @(posedge clk) begin
        if (push && !srst) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/ef_dac12_ctrl.sv
// DAC update controller: queues user codes in a small FIFO and plays them
// out to an external DAC as LOAD -> SETTLE(N+1 cycles) -> DONE sequences.
// Ports:
//   UserCLK, RESET   : clock, synchronous active-high reset
//   WRITE, DATA      : user write strobe and code
//   READY, EMPTY     : FIFO not full / FIFO empty
//   LEVEL            : FIFO occupancy
//   BUSY             : controller not idle
//   DONE             : one-cycle pulse when the current code has settled
//   OVERFLOW         : sticky, set when a write is dropped on a full FIFO
//   VALUE_top        : code register driving the DAC
//   LOAD_top         : DAC latch strobe
//   ENABLE_top       : DAC power enable
//   ConfigBits       : [3:0] settle count N, [4] power down while idle
module ef_dac12_ctrl
    import ef_dac12_pkg::*;
#(
    parameter int NUM_BITS     = DEFAULT_NUM_BITS,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int NoConfigBits = 5
) (
    input  logic                          UserCLK,
    input  logic                          RESET,
    input  logic                          WRITE,
    input  logic [NUM_BITS-1:0]           DATA,
    output logic                          READY,
    output logic                          EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          OVERFLOW,
    output logic [NUM_BITS-1:0]           VALUE_top,
    output logic                          LOAD_top,
    output logic                          ENABLE_top,
    input  logic [NoConfigBits-1:0]       ConfigBits
);

    state_t                 state_reg;
    logic [NUM_BITS-1:0]    code_reg;
    logic [SETTLE_BITS-1:0] settle_cnt_reg;
    logic                   load_reg;
    logic                   done_reg;
    logic                   busy_reg;
    logic                   overflow_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [NUM_BITS-1:0]    fifo_head;
    logic                   pop;
    logic [SETTLE_BITS-1:0] settle_n;
    logic                   pwrdn_idle;

    assign settle_n   = ConfigBits[SETTLE_BITS-1:0];
    assign pwrdn_idle = ConfigBits[SETTLE_BITS];

    // The FSM takes a new code only from IDLE or DONE, and only when the
    // FIFO held data at the start of the cycle.
    assign pop = ((state_reg == S_IDLE) || (state_reg == S_DONE)) && !fifo_empty;

    ef_dac12_fifo #(
        .WIDTH (NUM_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (UserCLK),
        .srst    (RESET),
        .wr_en   (WRITE),
        .wr_data (DATA),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (LEVEL)
    );

    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            state_reg      <= S_IDLE;
            code_reg       <= '0;
            settle_cnt_reg <= '0;
            load_reg       <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        code_reg  <= fifo_head;
                        state_reg <= S_LOAD;
                        load_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_reg      <= S_SETTLE;
                    settle_cnt_reg <= '0;
                end
                S_SETTLE: begin
                    // N is read live so a change lands on the next compare.
                    settle_cnt_reg <= settle_cnt_reg + SETTLE_BITS'(1);
                    if (settle_cnt_reg == settle_n) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!fifo_empty) begin
                        code_reg  <= fifo_head;
                        state_reg <= S_LOAD;
                        load_reg  <= 1'b1;
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            overflow_reg <= 1'b0;
        end else if (WRITE && fifo_full) begin
            overflow_reg <= 1'b1;
        end
    end

    assign READY      = !fifo_full;
    assign EMPTY      = fifo_empty;
    assign BUSY       = busy_reg;
    assign DONE       = done_reg;
    assign OVERFLOW   = overflow_reg;
    assign VALUE_top  = code_reg;
    assign LOAD_top   = load_reg;
    assign ENABLE_top = !(pwrdn_idle && (state_reg == S_IDLE));

endmodule

// File: doc/ef_dac12_ctrl.md
EF_DAC12_CTRL -- requirements
Module: ef_dac12_ctrl

Interface
REQ-001 Parameter NUM_BITS, default 12, SHALL set the DAC code width.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the sample-FIFO depth (power of two, at least 2).
REQ-003 Parameter NoConfigBits, default 5, SHALL set the width of ConfigBits.
REQ-004 UserCLK, input, 1: the single clock (external, shared), rising edge.
REQ-005 RESET, input, 1: synchronous, active-high reset.
REQ-006 WRITE, input, 1: user write strobe; pushes DATA when READY=1.
REQ-007 DATA, input, NUM_BITS: DAC code to queue.
REQ-008 READY, output, 1: FIFO not full.
REQ-009 EMPTY, output, 1: FIFO empty.
REQ-010 LEVEL, output, clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-011 BUSY, output, 1: state is not S_IDLE.
REQ-012 DONE, output, 1: one-cycle pulse when the current code has settled.
REQ-013 OVERFLOW, output, 1: sticky flag, set when a write is dropped.
REQ-014 VALUE_top, output (external), NUM_BITS: code to the analog DAC.
REQ-015 LOAD_top, output (external), 1: DAC latch strobe.
REQ-016 ENABLE_top, output (external), 1: DAC power enable.
REQ-017 ConfigBits, input (global), NoConfigBits: [3:0] SETTLE count N; [4] PWRDN_IDLE.

Function
REQ-018 A write SHALL be accepted only when WRITE=1 and the FIFO is not full at the start of the cycle; a pop in the same cycle SHALL NOT free a slot for it.
REQ-019 A write while full SHALL be dropped and SHALL set OVERFLOW on the next edge; the FIFO contents SHALL remain unchanged.
REQ-020 A simultaneous push and pop SHALL leave LEVEL unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The FSM SHALL have the states S_IDLE, S_LOAD, S_SETTLE and S_DONE.
REQ-022 In S_IDLE, if the FIFO is non-empty at the start of the cycle, the FSM SHALL pop the head into the code register and go to S_LOAD; a word written into an empty FIFO SHALL therefore appear on VALUE_top two edges after WRITE.
REQ-023 In S_LOAD, LOAD_top SHALL be 1 for exactly one cycle, and the FSM SHALL then go to S_SETTLE with the settle counter at 0.
REQ-024 In S_SETTLE, the settle counter SHALL increment each cycle, and the FSM SHALL go to S_DONE in the cycle where counter==N; the FSM SHALL spend N+1 cycles in S_SETTLE (N=0 gives one cycle).
REQ-025 In S_DONE, DONE SHALL be 1 for one cycle; the FSM SHALL then pop and go to S_LOAD if the FIFO is non-empty, otherwise go to S_IDLE.
REQ-026 Back-to-back update period SHALL be N+3 cycles.
REQ-027 VALUE_top SHALL be the registered code and SHALL change only on the edge that enters S_LOAD; it SHALL hold its last value in S_IDLE.
REQ-028 ENABLE_top SHALL be 0 only when PWRDN_IDLE=1 and the state is S_IDLE (combinational).
REQ-029 Changing N during S_SETTLE SHALL take effect on the next comparison.

Reset
REQ-030 On RESET=1 at an edge, the following SHALL be cleared regardless of state: state to S_IDLE, FIFO pointers and LEVEL to 0, code register to 0, settle counter to 0, OVERFLOW to 0.
REQ-031 After reset the outputs SHALL be: VALUE_top=0, LOAD_top=0, DONE=0, BUSY=0, READY=1, EMPTY=1.
REQ-032 RESET SHALL take priority over a WRITE in the same cycle, which SHALL be dropped; a reset mid-conversion SHALL abort it with no DONE pulse.

Structure
REQ-033 Package ef_dac12_pkg SHALL hold state_t and the default NUM_BITS and FIFO_DEPTH constants.
REQ-034 The FIFO SHALL be the sub-module ef_dac12_fifo (synchronous, registered pointers, with full, empty and level outputs).
REQ-035 The controller FSM, settle counter and code register SHALL reside in ef_dac12_ctrl.

Verification
REQ-036 Single write: N=3, write 0xABC into an empty FIFO at cycle 0 -> VALUE_top=0xABC and LOAD_top=1 at cycle 2, DONE=1 at cycle 7, BUSY=0 at cycle 8.
REQ-037 Stream: N=3, write 0x001, 0x002, 0x003 on consecutive cycles -> LOAD_top pulses at cycles 2, 8 and 14 with the codes in order.
REQ-038 Overflow: hold the FSM in S_SETTLE with N=15, write 6 words -> LEVEL=4, READY=0, OVERFLOW=1, words 5 and 6 never appear on VALUE_top.
REQ-039 N=0: 0x800 then 0xFFF -> update period 3 cycles.
REQ-040 Reset mid-settle with 2 words queued -> next cycle VALUE_top=0, EMPTY=1, no DONE pulse, and no LOAD_top until a new write.
REQ-041 PWRDN_IDLE=1 -> ENABLE_top=0 in S_IDLE and 1 from the S_LOAD cycle through S_DONE.
